// File: rtl/ttt_pkg.sv
// ttt_pkg: shared codes, FSM state, win lines and board helpers
// for the tic-tac-toe board controller and its win detector.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OCC   = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_TURN  = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef struct packed {
        logic [1:0] xoro;
        logic [1:0] row;
        logic [1:0] col;
    } move_t;

    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [3:0] cell_idx(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

    // Indices past 8 read as empty so out-of-range
    // moves never alias onto a real cell.
    function automatic logic [1:0] cell_at(
        input logic [17:0] b,
        input logic [3:0]  idx
    );
        logic [1:0] c;
        c = CELL_EMPTY;
        for (int k = 0; k < 9; k++) begin
            if (idx == 4'(k)) c = b[2*k +: 2];
        end
        return c;
    endfunction

    function automatic logic [17:0] set_cell(
        input logic [17:0] b,
        input logic [3:0]  idx,
        input logic [1:0]  v
    );
        logic [17:0] r;
        r = b;
        for (int k = 0; k < 9; k++) begin
            if (idx == 4'(k)) r[2*k +: 2] = v;
        end
        return r;
    endfunction

    function automatic logic [1:0] other(input logic [1:0] m);
        return (m == CELL_X) ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// ttt_win_detect: combinational three-in-a-row detector.
// Ports: board[17:0] in; win out (any line), win_mark[1:0] out.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    output logic        win,
    output logic [1:0]  win_mark
);

    always_comb begin
        win      = 1'b0;
        win_mark = CELL_EMPTY;
        for (int l = 0; l < 8; l++) begin
            if (!win
                && cell_at(board, WIN_LINES[l][0]) != CELL_EMPTY
                && cell_at(board, WIN_LINES[l][0])
                   == cell_at(board, WIN_LINES[l][1])
                && cell_at(board, WIN_LINES[l][1])
                   == cell_at(board, WIN_LINES[l][2])) begin
                win      = 1'b1;
                win_mark = cell_at(board, WIN_LINES[l][0]);
            end
        end
    end

endmodule

// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl: owns the board, validates valid/ready moves, detects
// win/draw. Ports: clk, rst_n, new_game, mv_valid/mv_ready, mv_xoro,
// mv_row, mv_col in; registers, turn, mv_err, err_code, move_count,
// game_over, winner out. `define UNDO_EN adds input undo (one level).
module ttt_board_ctrl
    import ttt_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        mv_valid,
    output logic        mv_ready,
    input  logic [1:0]  mv_xoro,
    input  logic [1:0]  mv_row,
    input  logic [1:0]  mv_col,
`ifdef UNDO_EN
    input  logic        undo,
`endif
    output logic [17:0] registers,
    output logic [1:0]  turn,
    output logic        mv_err,
    output logic [1:0]  err_code,
    output logic [3:0]  move_count,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_t      state, state_nx;
    move_t       mv;
    logic [3:0]  idx;
    logic        bad_range, bad_turn, bad_occ;
    logic        e_rng, e_trn, e_occ;
    logic        hs, legal, reject;
    logic        undo_go;
    logic        win;
    logic [1:0]  win_mark;
    logic [1:0]  code;

    logic [17:0] board_nx;
    logic [1:0]  turn_nx, err_code_nx, winner_nx;
    logic [3:0]  count_nx;
    logic        mv_err_nx, game_over_nx;

    assign mv        = {mv_xoro, mv_row, mv_col};
    assign idx       = cell_idx(mv.row, mv.col);
    assign bad_range = (mv.row == 2'd3) || (mv.col == 2'd3);
    assign bad_turn  = (mv.xoro != turn);
    assign bad_occ   = (cell_at(registers, idx) != CELL_EMPTY);

    // Mutually exclusive so the decoder below stays one-hot.
    assign e_rng = bad_range;
    assign e_trn = !bad_range && bad_turn;
    assign e_occ = !bad_range && !bad_turn && bad_occ;

`ifdef UNDO_EN
    logic [3:0] last_idx, last_idx_nx;
    logic       last_vld, last_vld_nx;
    assign undo_go = undo && last_vld
                     && (state == PLAY || state == DONE);
`else
    assign undo_go = 1'b0;
`endif

    // new_game and undo both steal the handshake edge.
    assign hs     = mv_valid && mv_ready && !new_game && !undo_go;
    assign legal  = hs && !(e_rng || e_trn || e_occ);
    assign reject = hs && (e_rng || e_trn || e_occ);

    ttt_win_detect u_win (
        .board    (registers),
        .win      (win),
        .win_mark (win_mark)
    );

    always_comb begin
        code = ERR_NONE;
        unique case (1'b1)
            e_rng:   code = ERR_RANGE;
            e_trn:   code = ERR_TURN;
            e_occ:   code = ERR_OCC;
            default: code = ERR_NONE;
        endcase
    end

    always_comb begin
        state_nx = state;
        mv_ready = (state == PLAY);
        unique case (state)
            PLAY:    if (legal) state_nx = CHECK;
            CHECK:   begin
                if (win || move_count == MAX_MOVES)
                    state_nx = DONE;
                else
                    state_nx = PLAY;
            end
            DONE:    state_nx = DONE;
            default: state_nx = PLAY;
        endcase
        if (undo_go)  state_nx = PLAY;
        if (new_game) state_nx = PLAY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PLAY;
        else        state <= state_nx;
    end

    always_comb begin
        board_nx     = registers;
        turn_nx      = turn;
        mv_err_nx    = 1'b0;
        err_code_nx  = err_code;
        count_nx     = move_count;
        game_over_nx = game_over;
        winner_nx    = winner;
`ifdef UNDO_EN
        last_idx_nx  = last_idx;
        last_vld_nx  = last_vld;
`endif
        if (legal) begin
            board_nx    = set_cell(registers, idx, mv.xoro);
            turn_nx     = other(turn);
            err_code_nx = ERR_NONE;
            if (move_count != MAX_MOVES)
                count_nx = move_count + 4'd1;
`ifdef UNDO_EN
            last_idx_nx = idx;
            last_vld_nx = 1'b1;
`endif
        end
        if (reject) begin
            mv_err_nx   = 1'b1;
            err_code_nx = code;
        end
        if (state == CHECK) begin
            if (win) begin
                game_over_nx = 1'b1;
                winner_nx    = win_mark;
            end else if (move_count == MAX_MOVES) begin
                game_over_nx = 1'b1;
                winner_nx    = WIN_DRAW;
            end
        end
`ifdef UNDO_EN
        if (undo_go) begin
            board_nx     = set_cell(registers, last_idx,
                                    CELL_EMPTY);
            turn_nx      = other(turn);
            game_over_nx = 1'b0;
            winner_nx    = WIN_NONE;
            last_vld_nx  = 1'b0;
            if (move_count != 4'd0)
                count_nx = move_count - 4'd1;
        end
`endif
        if (new_game) begin
            board_nx     = '0;
            turn_nx      = FIRST_PLAYER;
            err_code_nx  = ERR_NONE;
            count_nx     = 4'd0;
            game_over_nx = 1'b0;
            winner_nx    = WIN_NONE;
            mv_err_nx    = 1'b0;
`ifdef UNDO_EN
            last_vld_nx  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            registers  <= '0;
            turn       <= FIRST_PLAYER;
            mv_err     <= 1'b0;
            err_code   <= ERR_NONE;
            move_count <= 4'd0;
            game_over  <= 1'b0;
            winner     <= WIN_NONE;
        end else begin
            registers  <= board_nx;
            turn       <= turn_nx;
            mv_err     <= mv_err_nx;
            err_code   <= err_code_nx;
            move_count <= count_nx;
            game_over  <= game_over_nx;
            winner     <= winner_nx;
        end
    end

`ifdef UNDO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx <= 4'd0;
            last_vld <= 1'b0;
        end else begin
            last_idx <= last_idx_nx;
            last_vld <= last_vld_nx;
        end
    end
`endif

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb_ttt_board_ctrl: table-driven self-checking bench for
// ttt_board_ctrl with a queue scoreboard and reset corner cases.
module tb_ttt_board_ctrl;

    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_game, mv_valid, mv_ready, undo;
    logic [1:0]  mv_xoro, mv_row, mv_col;
    logic [17:0] registers;
    logic [1:0]  turn, err_code, winner;
    logic        mv_err, game_over;
    logic [3:0]  move_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        ng;
        logic        vld;
        logic [1:0]  x, r, c;
        logic        und;
        logic [17:0] brd;
        logic [1:0]  turn;
        logic        err;
        logic [1:0]  ec;
        logic [3:0]  cnt;
        logic        rdy;
        logic        go;
        logic [1:0]  win;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    ttt_board_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .mv_valid   (mv_valid),
        .mv_ready   (mv_ready),
        .mv_xoro    (mv_xoro),
        .mv_row     (mv_row),
        .mv_col     (mv_col),
`ifdef UNDO_EN
        .undo       (undo),
`endif
        .registers  (registers),
        .turn       (turn),
        .mv_err     (mv_err),
        .err_code   (err_code),
        .move_count (move_count),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm,
                       input logic [17:0] act,
                       input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(
        input logic ng, input logic vld,
        input logic [1:0] x, input logic [1:0] r,
        input logic [1:0] c, input logic und,
        input logic [17:0] brd, input logic [1:0] tn,
        input logic err, input logic [1:0] ec,
        input logic [3:0] cnt, input logic rdy,
        input logic go, input logic [1:0] win);
        vec_t v;
        v.ng = ng; v.vld = vld; v.x = x; v.r = r; v.c = c;
        v.und = und; v.brd = brd; v.turn = tn; v.err = err;
        v.ec = ec; v.cnt = cnt; v.rdy = rdy; v.go = go;
        v.win = win;
        vecs.push_back(v);
    endtask

    task automatic idle_in();
        new_game = 0; mv_valid = 0; undo = 0;
        mv_xoro = 0; mv_row = 0; mv_col = 0;
    endtask

    task automatic cmp_vec(input int i, input vec_t e);
        chk($sformatf("v%0d board", i), registers, e.brd);
        chk($sformatf("v%0d turn", i), 18'(turn), 18'(e.turn));
        chk($sformatf("v%0d mv_err", i), 18'(mv_err), 18'(e.err));
        chk($sformatf("v%0d err_code", i), 18'(err_code), 18'(e.ec));
        chk($sformatf("v%0d count", i), 18'(move_count), 18'(e.cnt));
        chk($sformatf("v%0d ready", i), 18'(mv_ready), 18'(e.rdy));
        chk($sformatf("v%0d game_over", i), 18'(game_over), 18'(e.go));
        chk($sformatf("v%0d winner", i), 18'(winner), 18'(e.win));
    endtask

    initial begin
        vec_t e;
        idle_in();
        rst_n = 0;

        // basic move, occupied / range / turn errors, held valid
        add(0,1,X,0,0,0, 18'h00001,O,0,0,1,0,0,0);
        add(0,0,0,0,0,0, 18'h00001,O,0,0,1,1,0,0);
        add(1,0,0,0,0,0, 18'h00000,X,0,0,0,1,0,0);
        add(0,1,X,1,1,0, 18'h00100,O,0,0,1,0,0,0);
        add(0,0,0,0,0,0, 18'h00100,O,0,0,1,1,0,0);
        add(0,1,O,1,1,0, 18'h00100,O,1,1,1,1,0,0);
        add(0,0,0,0,0,0, 18'h00100,O,0,1,1,1,0,0);
        add(0,1,O,3,0,0, 18'h00100,O,1,2,1,1,0,0);
        add(0,1,X,0,0,0, 18'h00100,O,1,3,1,1,0,0);
        add(0,1,O,0,0,0, 18'h00102,X,0,0,2,0,0,0);
        add(0,1,X,2,2,0, 18'h00102,X,0,0,2,1,0,0);
        add(0,1,X,2,2,0, 18'h10102,O,0,0,3,0,0,0);
        add(0,0,0,0,0,0, 18'h10102,O,0,0,3,1,0,0);
        add(1,1,O,2,0,0, 18'h00000,X,0,0,0,1,0,0);
        add(0,1,2'b00,2,2,0, 18'h00000,X,1,3,0,1,0,0);
        add(0,1,2'b11,0,3,0, 18'h00000,X,1,2,0,1,0,0);
        add(0,0,0,0,0,0, 18'h00000,X,0,2,0,1,0,0);

        // X wins on the top row
        add(1,0,0,0,0,0, 18'h00000,X,0,0,0,1,0,0);
        add(0,1,X,0,0,0, 18'h00001,O,0,0,1,0,0,0);
        add(0,0,0,0,0,0, 18'h00001,O,0,0,1,1,0,0);
        add(0,1,O,1,0,0, 18'h00081,X,0,0,2,0,0,0);
        add(0,0,0,0,0,0, 18'h00081,X,0,0,2,1,0,0);
        add(0,1,X,0,1,0, 18'h00085,O,0,0,3,0,0,0);
        add(0,0,0,0,0,0, 18'h00085,O,0,0,3,1,0,0);
        add(0,1,O,1,1,0, 18'h00285,X,0,0,4,0,0,0);
        add(0,0,0,0,0,0, 18'h00285,X,0,0,4,1,0,0);
        add(0,1,X,0,2,0, 18'h00295,O,0,0,5,0,0,0);
        add(0,0,0,0,0,0, 18'h00295,O,0,0,5,0,1,X);
        add(0,1,O,2,2,0, 18'h00295,O,0,0,5,0,1,X);
        add(0,1,O,2,2,0, 18'h00295,O,0,0,5,0,1,X);
`ifdef UNDO_EN
        add(0,0,0,0,0,1, 18'h00285,X,0,0,4,1,0,0);
        add(0,0,0,0,0,1, 18'h00285,X,0,0,4,1,0,0);
        add(0,1,X,2,2,0, 18'h10285,O,0,0,5,0,0,0);
        add(0,0,0,0,0,0, 18'h10285,O,0,0,5,1,0,0);
        add(0,1,O,2,1,1, 18'h00285,X,0,0,4,1,0,0);
`endif

        // nine moves, no line: draw
        add(1,0,0,0,0,0, 18'h00000,X,0,0,0,1,0,0);
        add(0,1,X,0,0,0, 18'h00001,O,0,0,1,0,0,0);
        add(0,0,0,0,0,0, 18'h00001,O,0,0,1,1,0,0);
        add(0,1,O,0,1,0, 18'h00009,X,0,0,2,0,0,0);
        add(0,0,0,0,0,0, 18'h00009,X,0,0,2,1,0,0);
        add(0,1,X,0,2,0, 18'h00019,O,0,0,3,0,0,0);
        add(0,0,0,0,0,0, 18'h00019,O,0,0,3,1,0,0);
        add(0,1,O,1,1,0, 18'h00219,X,0,0,4,0,0,0);
        add(0,0,0,0,0,0, 18'h00219,X,0,0,4,1,0,0);
        add(0,1,X,1,0,0, 18'h00259,O,0,0,5,0,0,0);
        add(0,0,0,0,0,0, 18'h00259,O,0,0,5,1,0,0);
        add(0,1,O,1,2,0, 18'h00A59,X,0,0,6,0,0,0);
        add(0,0,0,0,0,0, 18'h00A59,X,0,0,6,1,0,0);
        add(0,1,X,2,1,0, 18'h04A59,O,0,0,7,0,0,0);
        add(0,0,0,0,0,0, 18'h04A59,O,0,0,7,1,0,0);
        add(0,1,O,2,0,0, 18'h06A59,X,0,0,8,0,0,0);
        add(0,0,0,0,0,0, 18'h06A59,X,0,0,8,1,0,0);
        add(0,1,X,2,2,0, 18'h16A59,O,0,0,9,0,0,0);
        add(0,0,0,0,0,0, 18'h16A59,O,0,0,9,0,1,2'b11);
        add(0,1,X,0,0,0, 18'h16A59,O,0,0,9,0,1,2'b11);
        add(1,0,0,0,0,0, 18'h00000,X,0,0,0,1,0,0);

        // reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst board", registers, 18'h0);
        chk("rst turn", 18'(turn), 18'(X));
        chk("rst ready", 18'(mv_ready), 18'd1);
        chk("rst count", 18'(move_count), 18'd0);
        chk("rst over", 18'(game_over), 18'd0);
        chk("rst winner", 18'(winner), 18'd0);
        chk("rst err", 18'({mv_err, err_code}), 18'd0);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            new_game = vecs[i].ng;
            mv_valid = vecs[i].vld;
            mv_xoro  = vecs[i].x;
            mv_row   = vecs[i].r;
            mv_col   = vecs[i].c;
            undo     = vecs[i].und;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            cmp_vec(i, e);
        end
        idle_in();

        // async reset while the check is pending
        mv_valid = 1; mv_xoro = X; mv_row = 1; mv_col = 2;
        @(posedge clk);
        #1;
        idle_in();
        chk("mid board", registers, 18'h00800 >> 1);
        chk("mid ready", 18'(mv_ready), 18'd0);
        #2 rst_n = 0;
        #1;
        chk("mid rst board", registers, 18'h0);
        chk("mid rst ready", 18'(mv_ready), 18'd1);
        chk("mid rst count", 18'(move_count), 18'd0);
        chk("mid rst turn", 18'(turn), 18'(X));
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        chk("post rst ready", 18'(mv_ready), 18'd1);
        chk("post rst over", 18'(game_over), 18'd0);
        chk("post rst board", registers, 18'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
